// File: rtl/control_sequencer_if.sv
// Control-unit <-> datapath bundle: IR/condition/run-control inputs and all datapath strobes.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        con, start, stop;
  logic [4:0]  opcode;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONN_in;
  logic        PCout, MDRout, ZLowOut, ZHighOut, HIout, LOout, InPortOut;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortIn, incPC, read, write;
  logic        run;

  modport slave (
    input  ir, con, start, stop,
    output opcode, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONN_in,
           PCout, MDRout, ZLowOut, ZHighOut, HIout, LOout, InPortOut,
           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortIn, incPC, read, write, run
  );

  modport master (
    output ir, con, start, stop,
    input  opcode, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONN_in,
           PCout, MDRout, ZLowOut, ZHighOut, HIout, LOout, InPortOut,
           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortIn, incPC, read, write, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0..T2, opcode-driven execute T3..T7, HALT with run control.
module control_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input logic clk,
  input logic clr,
  control_sequencer_if.slave bus
);
  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef enum logic [3:0] {C_LD, C_LDI, C_ST, C_RALU, C_IALU, C_MULDIV, C_UNARY, C_BR,
                            C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP} class_t;

  localparam logic [2:0] LP_WAIT = 3'(MEM_WAIT);
  localparam int B_GRA = 0, B_GRB = 1, B_GRC = 2, B_RIN = 3, B_ROUT = 4, B_BAOUT = 5, B_COUT = 6;
  localparam int B_CONNIN = 7, B_PCOUT = 8, B_MDROUT = 9, B_ZLOWOUT = 10, B_ZHIGHOUT = 11;
  localparam int B_HIOUT = 12, B_LOOUT = 13, B_INPORTOUT = 14, B_PCIN = 15, B_IRIN = 16;
  localparam int B_MARIN = 17, B_MDRIN = 18, B_YIN = 19, B_ZIN = 20, B_HIIN = 21, B_LOIN = 22;
  localparam int B_OUTPORTIN = 23, B_INCPC = 24, B_READ = 25, B_WRITE = 26;

  function automatic class_t f_class(input logic [4:0] op);
    class_t c;
    case (op) inside
      5'b00000:          c = C_LD;
      5'b00001:          c = C_LDI;
      5'b00010:          c = C_ST;
      [5'd3:5'd11]:      c = C_RALU;
      [5'd12:5'd14]:     c = C_IALU;
      5'b01111, 5'b10000: c = C_MULDIV;
      5'b10001, 5'b10010: c = C_UNARY;
      5'b10011:          c = C_BR;
      5'b10100:          c = C_JR;
      5'b10110:          c = C_IN;
      5'b10111:          c = C_OUT;
      5'b11000:          c = C_MFHI;
      5'b11001:          c = C_MFLO;
      5'b11011:          c = C_HALT;
      default:           c = C_NOP;
    endcase
    return c;
  endfunction

  function automatic state_t f_last(input class_t c);
    state_t s;
    case (c)
      C_LD, C_ST:             s = T7;
      C_LDI, C_RALU, C_IALU:  s = T5;
      C_MULDIV, C_BR:         s = T6;
      C_UNARY:                s = T4;
      default:                s = T3;
    endcase
    return s;
  endfunction

  function automatic logic [26:0] f_strobes(input state_t s, input class_t c, input logic cn);
    logic [26:0] v;
    v = 27'd0;
    case (s)
      T0: begin v[B_PCOUT] = 1'b1; v[B_MARIN] = 1'b1; v[B_INCPC] = 1'b1; v[B_ZIN] = 1'b1; end
      T1: begin v[B_ZLOWOUT] = 1'b1; v[B_PCIN] = 1'b1; v[B_READ] = 1'b1; v[B_MDRIN] = 1'b1; end
      T2: begin v[B_MDROUT] = 1'b1; v[B_IRIN] = 1'b1; end
      T3: case (c)
        C_LD, C_LDI, C_ST: begin v[B_GRB] = 1'b1; v[B_BAOUT] = 1'b1; v[B_YIN] = 1'b1; end
        C_RALU, C_IALU:    begin v[B_GRB] = 1'b1; v[B_ROUT] = 1'b1; v[B_YIN] = 1'b1; end
        C_MULDIV:          begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_YIN] = 1'b1; end
        C_UNARY:           begin v[B_GRB] = 1'b1; v[B_ROUT] = 1'b1; v[B_ZIN] = 1'b1; end
        C_BR:              begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_CONNIN] = 1'b1; end
        C_JR:              begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_PCIN] = 1'b1; end
        C_IN:              begin v[B_INPORTOUT] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
        C_OUT:             begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_OUTPORTIN] = 1'b1; end
        C_MFHI:            begin v[B_HIOUT] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
        C_MFLO:            begin v[B_LOOUT] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
        default:           v = 27'd0;
      endcase
      T4: case (c)
        C_LD, C_LDI, C_ST, C_IALU: begin v[B_COUT] = 1'b1; v[B_ZIN] = 1'b1; end
        C_RALU:   begin v[B_GRC] = 1'b1; v[B_ROUT] = 1'b1; v[B_ZIN] = 1'b1; end
        C_MULDIV: begin v[B_GRB] = 1'b1; v[B_ROUT] = 1'b1; v[B_ZIN] = 1'b1; end
        C_UNARY:  begin v[B_ZLOWOUT] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
        C_BR:     begin v[B_PCOUT] = 1'b1; v[B_YIN] = 1'b1; end
        default:  v = 27'd0;
      endcase
      T5: case (c)
        C_LD, C_ST:            begin v[B_ZLOWOUT] = 1'b1; v[B_MARIN] = 1'b1; end
        C_LDI, C_RALU, C_IALU: begin v[B_ZLOWOUT] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
        C_MULDIV:              begin v[B_ZLOWOUT] = 1'b1; v[B_LOIN] = 1'b1; end
        C_BR:                  begin v[B_COUT] = 1'b1; v[B_ZIN] = 1'b1; end
        default:               v = 27'd0;
      endcase
      T6: case (c)
        C_LD:     begin v[B_READ] = 1'b1; v[B_MDRIN] = 1'b1; end
        C_ST:     begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_MDRIN] = 1'b1; end
        C_MULDIV: begin v[B_ZHIGHOUT] = 1'b1; v[B_HIIN] = 1'b1; end
        C_BR:     begin v[B_ZLOWOUT] = cn; v[B_PCIN] = cn; end
        default:  v = 27'd0;
      endcase
      T7: case (c)
        C_LD:    begin v[B_MDROUT] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
        C_ST:    v[B_WRITE] = 1'b1;
        default: v = 27'd0;
      endcase
      default: v = 27'd0;
    endcase
    return v;
  endfunction

  state_t      r_state, w_next, w_boundary;
  class_t      w_class;
  logic [2:0]  r_wait, w_wait_nxt;
  logic        r_stop, w_stop_pend, w_hold, w_run;
  logic [26:0] r_str, w_str;
  logic [4:0]  r_opcode, w_opcode;
  logic        r_run;
  logic        w_unused_ir;

  assign w_class     = f_class(bus.ir[31:27]);
  assign w_stop_pend = r_stop | bus.stop;
  assign w_boundary  = w_stop_pend ? HALT : T0;
  assign w_hold      = (r_state == T1) || ((r_state == T6) && (w_class == C_LD));
  assign w_unused_ir = ^bus.ir[26:0];

  // Next state; memory-read steps stay put until the wait counter reaches MEM_WAIT.
  always_comb begin
    w_next     = r_state;
    w_wait_nxt = 3'd0;
    case (r_state)
      RST, T2: w_next = (r_state == RST) ? T0 : T3;
      T0:      w_next = T1;
      T1, T3, T4, T5, T6, T7: begin
        if (w_hold && (r_wait != LP_WAIT)) begin
          w_wait_nxt = r_wait + 3'd1;
        end else if (r_state == T1) begin
          w_next = T2;
        end else if ((r_state == T3) && (w_class == C_HALT)) begin
          w_next = HALT;
        end else if (r_state == f_last(w_class)) begin
          w_next = w_boundary;
        end else begin
          w_next = state_t'(r_state + 4'd1);
        end
      end
      HALT:    w_next = (bus.start && !bus.stop) ? T0 : HALT;
      default: w_next = RST;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_str    = f_strobes(w_next, w_class, bus.con);
    w_run    = (w_next != RST) && (w_next != HALT);
    w_opcode = 5'b00000;
    if ((w_next >= T3) && (w_next <= T7)) begin
      if ((w_class == C_LD) || (w_class == C_LDI) || (w_class == C_ST) || (w_class == C_BR)) begin
        w_opcode = 5'b00011;
      end else begin
        w_opcode = bus.ir[31:27];
      end
    end else begin
      w_opcode = 5'b00000;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= RST;
      r_wait   <= 3'd0;
      r_stop   <= 1'b0;
      r_str    <= 27'd0;
      r_opcode <= 5'b00000;
      r_run    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wait   <= w_wait_nxt;
      r_stop   <= (w_next == HALT) ? 1'b0 : w_stop_pend;
      r_str    <= w_str;
      r_opcode <= w_opcode;
      r_run    <= w_run;
    end
  end

  assign bus.opcode    = r_opcode;
  assign bus.run       = r_run;
  assign bus.Gra       = r_str[B_GRA];
  assign bus.Grb       = r_str[B_GRB];
  assign bus.Grc       = r_str[B_GRC];
  assign bus.Rin       = r_str[B_RIN];
  assign bus.Rout      = r_str[B_ROUT];
  assign bus.BAout     = r_str[B_BAOUT];
  assign bus.Cout      = r_str[B_COUT];
  assign bus.CONN_in   = r_str[B_CONNIN];
  assign bus.PCout     = r_str[B_PCOUT];
  assign bus.MDRout    = r_str[B_MDROUT];
  assign bus.ZLowOut   = r_str[B_ZLOWOUT];
  assign bus.ZHighOut  = r_str[B_ZHIGHOUT];
  assign bus.HIout     = r_str[B_HIOUT];
  assign bus.LOout     = r_str[B_LOOUT];
  assign bus.InPortOut = r_str[B_INPORTOUT];
  assign bus.PCin      = r_str[B_PCIN];
  assign bus.IRin      = r_str[B_IRIN];
  assign bus.MARin     = r_str[B_MARIN];
  assign bus.MDRin     = r_str[B_MDRIN];
  assign bus.Yin       = r_str[B_YIN];
  assign bus.Zin       = r_str[B_ZIN];
  assign bus.HIin      = r_str[B_HIIN];
  assign bus.LOin      = r_str[B_LOIN];
  assign bus.OutPortIn = r_str[B_OUTPORTIN];
  assign bus.incPC     = r_str[B_INCPC];
  assign bus.read      = r_str[B_READ];
  assign bus.write     = r_str[B_WRITE];
endmodule
